// File: rtl/cut_sequencer.sv
// cut_sequencer: runs N feed/cut/settle rounds per job under a watchdog, reporting done, error and progress.
module cut_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 300000000,
  parameter int unsigned CNT_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_cuts_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [CNT_W-1:0] cuts_done_o,
  output logic             feed_o,
  input  logic             feed_done_i,
  output logic             cut_o,
  input  logic             cut_end_i
);
  typedef enum logic [2:0] {IDLE, FEED, CUT, SETTLE, DONE, ERR} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d, cuts_q, cuts_d;
  logic [31:0]      tmr_q, tmr_d;
  logic             err_q, err_d, feed_done_q, cut_end_q;
  logic             feed_rise, cut_rise, expired, settled, timing;
  assign feed_rise = feed_done_i & ~feed_done_q;
  assign cut_rise  = cut_end_i & ~cut_end_q;
  assign expired   = tmr_q == TIMEOUT_CYCLES - 1;
  assign settled   = tmr_q == SETTLE_CYCLES - 1;
  assign timing    = state_q == FEED || state_q == CUT || state_q == SETTLE;
  // Abort is tested first in every active state; an edge beats a same-cycle watchdog expiry.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cuts_d  = cuts_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start_i && !abort_i) begin
        num_d   = num_cuts_i;
        cuts_d  = '0;
        err_d   = 1'b0;
        state_d = num_cuts_i == '0 ? DONE : FEED;
      end
      FEED:   state_d = abort_i ? IDLE : feed_rise ? CUT : expired ? ERR : FEED;
      CUT: begin
        state_d = abort_i ? IDLE : cut_rise ? SETTLE : expired ? ERR : CUT;
        cuts_d  = !abort_i && cut_rise ? cuts_q + 1'b1 : cuts_q;
      end
      SETTLE: state_d = abort_i ? IDLE : !settled ? SETTLE : cuts_q == num_q ? DONE : FEED;
      DONE:   state_d = IDLE;
      ERR:    state_d = abort_i ? IDLE : ERR;
      default: state_d = IDLE;
    endcase
    err_d = state_d == ERR ? 1'b1 : err_d;
    tmr_d = state_d != state_q ? '0 : timing ? tmr_q + 1'b1 : tmr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      num_q       <= '0;
      cuts_q      <= '0;
      tmr_q       <= '0;
      err_q       <= 1'b0;
      feed_done_q <= 1'b0;
      cut_end_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      cuts_q      <= cuts_d;
      tmr_q       <= tmr_d;
      err_q       <= err_d;
      feed_done_q <= feed_done_i;
      cut_end_q   <= cut_end_i;
    end
  end
  assign feed_o      = state_q == FEED;
  assign cut_o       = state_q == CUT;
  assign busy_o      = timing;
  assign done_o      = state_q == DONE;
  assign error_o     = err_q;
  assign cuts_done_o = cuts_q;
endmodule

// File: tb/tb_cut_sequencer.sv
// tb_cut_sequencer: reactive feed/cut environment with randomized timing; job timelines predicted arithmetically.
module tb_cut_sequencer;
  localparam int S  = 4;
  localparam int TO = 100;
  localparam int W  = 4;
  logic         clk = 0, rst = 1, start_i = 0, abort_i = 0, feed_done_i = 0, cut_end_i = 0;
  logic [W-1:0] num_cuts_i = '0;
  logic         busy_o, done_o, error_o, feed_o, cut_o;
  logic [W-1:0] cuts_done_o;
  int n_chk = 0, n_pass = 0;
  int feed_dly = 10, cut_dly = 30, hold_len = 20;
  int feed_cnt = 0, cut_cnt = 0, hold_cnt = 0;
  bit no_feed = 0, cut_in_feed = 0;
  always #5 clk = ~clk;
  cut_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_cuts_i(num_cuts_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .cuts_done_o(cuts_done_o),
    .feed_o(feed_o), .feed_done_i(feed_done_i), .cut_o(cut_o), .cut_end_i(cut_end_i)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  // Feed driver pulses done feed_dly cycles after feed_o rises; cut driver raises end-of-swing cut_dly cycles after cut_o rises and holds it hold_len cycles.
  always @(posedge clk) begin
    bit pulse;
    #1;
    pulse = 0;
    feed_done_i = 0;
    if (hold_cnt > 0) hold_cnt--;
    if (feed_o) begin
      if (feed_cnt == feed_dly && !no_feed) feed_done_i = 1;
      pulse = cut_in_feed && feed_cnt == 1;
      feed_cnt++;
    end else feed_cnt = 0;
    if (cut_o) begin
      if (cut_cnt == cut_dly) hold_cnt = hold_len;
      cut_cnt++;
    end else cut_cnt = 0;
    cut_end_i = hold_cnt > 0 || pulse;
  end
  // Each round is feed (fd+1), cut (cd+1), settle (S) cycles; done follows the last round.
  task automatic run_job(input int n, input int fd, input int cd, input int hold, input bit cif);
    int cyc = 0, fl = 0, cl = 0, sl = 0, rounds = 0, rise_at = -10;
    bit prev_ce = 0;
    feed_dly = fd; cut_dly = cd; hold_len = hold; cut_in_feed = cif; no_feed = 0;
    start_i = 1; num_cuts_i = n[W-1:0];
    @(negedge clk);
    start_i = 0;
    check("err_clr", error_o, 0);
    forever begin
      if (feed_o) fl++;
      else if (fl > 0) begin check("feed_len", fl, fd + 1); fl = 0; end
      if (cut_o && cut_end_i && !prev_ce) rise_at = cyc;
      if (cut_o) cl++;
      else if (cl > 0) begin
        rounds++;
        check("cut_len", cl, cd + 1);
        check("cut_fall", cyc - rise_at, 1);
        check("cuts_step", cuts_done_o, rounds);
        cl = 0;
      end
      if (busy_o && !feed_o && !cut_o) sl++;
      else if (sl > 0) begin check("settle_len", sl, S); sl = 0; end
      if (done_o || cyc >= 5000) break;
      prev_ce = cut_end_i;
      cyc++;
      @(negedge clk);
    end
    check("done_seen", done_o, 1);
    check("job_len", cyc, n * (fd + cd + 2 + S));
    check("rounds", rounds, n);
    check("cuts_final", cuts_done_o, n);
    @(negedge clk);
    check("done_width", done_o, 0);
    check("busy_after", busy_o, 0);
  endtask
  task automatic start_to_second_cut();
    int cnt = 0;
    feed_dly = 5; cut_dly = 40; hold_len = 2; cut_in_feed = 0; no_feed = 0;
    start_i = 1; num_cuts_i = 3;
    @(negedge clk);
    start_i = 0;
    while (!(cut_o && cuts_done_o == 1) && cnt < 500) begin cnt++; @(negedge clk); end
    check("reach_cut2", cut_o, 1);
  endtask
  initial begin
    int cnt;
    bit seen;
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", error_o, 0);
    check("rst_feed", feed_o, 0);
    check("rst_cut", cut_o, 0);
    check("rst_cuts", cuts_done_o, 0);
    rst = 0;
    @(negedge clk);
    run_job(3, 10, 30, 20, 0);
    idle(40);
    run_job(0, 0, 0, 1, 0);
    run_job(1, 5, 10, 500, 0);
    idle(520);
    run_job(2, 8, 6, 1, 1);
    idle(10);
    run_job(2, TO - 1, TO - 1, 3, 0);
    idle(10);
    run_job(15, 0, 0, 1, 0);
    idle(10);
    for (int j = 0; j < 8; j++) begin
      int n, fd, cd, hm;
      n  = $urandom_range(1, 6);
      fd = $urandom_range(0, 20);
      cd = $urandom_range(0, 40);
      hm = fd + cd + S + 1;
      if (hm > 40) hm = 40;
      run_job(n, fd, cd, $urandom_range(1, hm), 0);
      idle(45);
    end
    no_feed = 1;
    start_i = 1; num_cuts_i = 2;
    @(negedge clk);
    start_i = 0;
    cnt = 0;
    while (feed_o && cnt < 1000) begin cnt++; @(negedge clk); end
    check("to_feed_len", cnt, TO);
    check("to_err", error_o, 1);
    check("to_feed_off", feed_o, 0);
    check("to_busy", busy_o, 0);
    idle(5);
    check("to_err_hold", error_o, 1);
    abort_i = 1;
    @(negedge clk);
    abort_i = 0;
    check("to_abort_err", error_o, 1);
    check("to_abort_busy", busy_o, 0);
    run_job(1, 3, 3, 1, 0);
    idle(10);
    start_to_second_cut();
    abort_i = 1;
    @(negedge clk);
    abort_i = 0;
    check("ab_cut", cut_o, 0);
    check("ab_feed", feed_o, 0);
    check("ab_busy", busy_o, 0);
    check("ab_cuts", cuts_done_o, 1);
    seen = 0;
    repeat (10) begin seen |= done_o; @(negedge clk); end
    check("ab_no_done", seen, 0);
    start_i = 1; abort_i = 1; num_cuts_i = 0;
    @(negedge clk);
    start_i = 0; abort_i = 0;
    check("sa_done", done_o, 0);
    check("sa_busy", busy_o, 0);
    check("sa_cuts", cuts_done_o, 1);
    idle(45);
    start_to_second_cut();
    #2 rst = 1;
    #1;
    check("rc_cut", cut_o, 0);
    check("rc_feed", feed_o, 0);
    check("rc_busy", busy_o, 0);
    check("rc_done", done_o, 0);
    check("rc_err", error_o, 0);
    check("rc_cuts", cuts_done_o, 0);
    @(negedge clk);
    rst = 0;
    idle(45);
    run_job(2, 4, 7, 3, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
